// File: rtl/trackball_pulse_gen.sv
// trackball_pulse_gen: turns signed movement requests into du/cten_n/count_clk pulse trains for a 4-bit up/down counter
module trackball_pulse_gen #(
    parameter int unsigned DELTA_W   = 5,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned HIGH_CYC  = 2,
    parameter int unsigned LOW_CYC   = 2
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic [DELTA_W-1:0] delta,
    input  logic               delta_valid,
    output logic               delta_ready,
    input  logic               abort,
    output logic               du,
    output logic               cten_n,
    output logic               count_clk,
    output logic               busy,
    output logic               done,
    output logic [3:0]         shadow_q
);
    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_e;
    localparam logic [7:0] SETUP_T = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HIGH_T  = 8'(HIGH_CYC - 1);
    localparam logic [7:0] LOW_T   = 8'(LOW_CYC - 1);
    state_e             state_q, state_d;
    logic [DELTA_W-1:0] rem_q, rem_d, mag;
    logic [7:0]         tmr_q, tmr_d;
    logic [3:0]         shadow_d;
    logic               du_q, du_d, cten_n_q, cten_n_d, clk_q, clk_d;
    logic               busy_q, busy_d, done_q, done_d, ready_q, ready_d, abort_q, abort_d;
    // most-negative request wraps to 2^(DELTA_W-1), which reads correctly as unsigned
    assign mag = delta[DELTA_W-1] ? -delta : delta;
    // next-state: every output is registered so count_clk cannot glitch
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        tmr_d    = tmr_q;
        du_d     = du_q;
        cten_n_d = cten_n_q;
        clk_d    = clk_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        shadow_d = shadow_q;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: if (delta_valid && ready_q) begin
                du_d  = delta[DELTA_W-1];
                rem_d = mag;
                if (mag == '0) done_d = 1'b1;
                else begin
                    state_d  = SETUP;
                    cten_n_d = 1'b0;
                    busy_d   = 1'b1;
                    tmr_d    = SETUP_T;
                end
            end
            SETUP: if (abort) begin
                state_d  = IDLE;
                cten_n_d = 1'b1;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end else if (tmr_q == 8'd0) begin
                state_d  = HIGH;
                clk_d    = 1'b1;
                shadow_d = du_q ? shadow_q - 4'd1 : shadow_q + 4'd1;
                rem_d    = rem_q - DELTA_W'(1);
                tmr_d    = HIGH_T;
            end else tmr_d = tmr_q - 8'd1;
            HIGH: begin
                abort_d = abort_q | abort;
                if (tmr_q == 8'd0) begin
                    state_d = LOW;
                    clk_d   = 1'b0;
                    tmr_d   = LOW_T;
                end else tmr_d = tmr_q - 8'd1;
            end
            default: if (tmr_q != 8'd0) begin
                abort_d = abort_q | abort;
                tmr_d   = tmr_q - 8'd1;
            end else if (rem_q == '0 || abort_q || abort) begin
                state_d  = IDLE;
                cten_n_d = 1'b1;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end else begin
                state_d  = HIGH;
                clk_d    = 1'b1;
                shadow_d = du_q ? shadow_q - 4'd1 : shadow_q + 4'd1;
                rem_d    = rem_q - DELTA_W'(1);
                tmr_d    = HIGH_T;
            end
        endcase
        ready_d = (state_d == IDLE) && !done_d;
    end
    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            tmr_q    <= 8'd0;
            du_q     <= 1'b0;
            cten_n_q <= 1'b1;
            clk_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            abort_q  <= 1'b0;
            shadow_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            tmr_q    <= tmr_d;
            du_q     <= du_d;
            cten_n_q <= cten_n_d;
            clk_q    <= clk_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            abort_q  <= abort_d;
            shadow_q <= shadow_d;
        end
    end
    assign delta_ready = ready_q;
    assign du          = du_q;
    assign cten_n      = cten_n_q;
    assign count_clk   = clk_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: doc/trackball_pulse_gen.md
Name: trackball_pulse_gen

Overview:
- Transmitter side of the trackball count interface.
- Converts signed movement requests into the direction, count-enable and count-clock waveform that the loadable 4-bit up/down counters consume.
- Sits between the input-stimulus/emulation logic and the player-position counters.
- Keeps a 4-bit shadow of the value the downstream counter must hold, for self-check.

Parameters:
- DELTA_W, 5, width of the signed movement request (two's complement).
- SETUP_CYC, 1, cycles the direction is held stable with count enabled before the first count edge (1..255).
- HIGH_CYC, 2, cycles count_clk is high per pulse (1..255).
- LOW_CYC, 2, cycles count_clk is low after each pulse (1..255).

Ports:
- clk  in  1  system clock; all state on posedge.
- reset_L  in  1  asynchronous active-low reset.
- delta  in  DELTA_W  signed movement request; positive = count up, negative = count down.
- delta_valid  in  1  request valid.
- delta_ready  out  1  block can accept a request.
- abort  in  1  stop after the current pulse completes.
- du  out  1  direction to counter; 0 = up, 1 = down.
- cten_n  out  1  active-low count enable to counter.
- count_clk  out  1  count clock; the counter advances on its rising edge.
- busy  out  1  request in progress.
- done  out  1  one-cycle pulse when a request finishes or is aborted.
- shadow_q  out  4  expected counter value after all issued edges; wraps modulo 16.

Behaviour:
- Reset (async, reset_L=0) values:
  - State IDLE.
  - du=0, cten_n=1, count_clk=0, busy=0, done=0, delta_ready=0, shadow_q=4'h0.
  - Remaining-count and phase timer cleared.
- Handshake:
  - delta_ready=1 only in IDLE with reset deasserted.
  - A transfer occurs on a posedge where delta_valid & delta_ready.
  - delta must be held while valid and not ready.
- Capture on transfer:
  - du <= sign bit of delta.
  - remaining <= |delta|, DELTA_W bits unsigned; the most-negative value -2^(DELTA_W-1) yields magnitude 2^(DELTA_W-1), so 16 for the default.
  - If magnitude=0: stay IDLE, pulse done next cycle, no cten_n/count_clk activity.
  - Otherwise go to SETUP.
- SETUP:
  - cten_n=0, count_clk=0, busy=1.
  - Lasts SETUP_CYC cycles, then go to HIGH.
- HIGH:
  - count_clk=1 for HIGH_CYC cycles.
  - On entry (the rising edge): shadow_q += 1 if du=0, else shadow_q -= 1 (modulo 16); remaining -= 1.
  - Then go to LOW.
- LOW:
  - count_clk=0 for LOW_CYC cycles.
  - On expiry:
    - if remaining=0 or abort was sampled high at any point since the last HIGH entry, go to IDLE;
    - else go to HIGH.
- Return to IDLE:
  - cten_n=1, busy=0, done=1 for exactly one cycle.
  - delta_ready=1 from the following cycle.
- Invariants:
  - du changes only in IDLE.
  - du is stable for the whole time cten_n=0.
  - cten_n is low for the whole time count_clk toggles.
  - No count_clk glitches: outputs are registered.
- Abort:
  - Abort in SETUP: go to IDLE with no pulse issued; done pulses.
  - Abort in HIGH or LOW: the current pulse completes its full HIGH and LOW phases, then IDLE.
  - Abort in IDLE: ignored.
- Period: each pulse takes HIGH_CYC+LOW_CYC cycles. Total busy cycles = SETUP_CYC + N*(HIGH_CYC+LOW_CYC).
- Reset mid-operation: all outputs return to reset values immediately (count_clk may drop mid-pulse). shadow_q resets to 0, and the downstream counter must be reloaded by the system.
- Simultaneous events:
  - Abort and the last pulse's LOW expiry coincide: go to IDLE with a single done.
  - delta_valid asserted during the done cycle: not accepted, since ready is 0; accepted the next cycle.

Test Plan:
- Reset, then delta=+3, default params -> SETUP 1 cycle, then 3 pulses each 2 high/2 low; du=0; shadow_q 0→1→2→3; busy for 13 cycles; one done pulse.
- From shadow_q=1, delta=-2 -> du=1 before cten_n falls; 2 pulses; shadow_q 1→0→F (wrap); done once.
- delta=-16 (DELTA_W=5) -> 16 pulses; shadow_q returns to its starting value; du=1 throughout.
- delta=0 -> no cten_n/count_clk activity; done high one cycle after transfer; ready high the cycle after done.
- delta=+7, abort pulsed during the 3rd HIGH -> exactly 3 rising edges, shadow_q=3, then IDLE with done.
- delta=+5, reset_L low during the 2nd LOW -> outputs immediately at reset values, shadow_q=0; a new delta=+1 after release yields 1 pulse and shadow_q=1.
